uart_rx: RTL and testbench

- Serial receiver for the UART link. Counterpart of the existing transmitter: 8N1 framing, LSB first, idle-high line.
- Samples the asynchronous line using a 16x oversample tick and validates start and stop bits.
- Presents each received byte on a valid/ready output handshake to the RX FIFO or consumer.
- Reports framing and overrun errors as single-cycle pulses.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults, RX state encoding and
// the oversample tick positions used to find the middle of a bit.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Tick index at the middle of the start bit, counted from its detection.
    function automatic int mid_start(input int os);
        return os / 2 - 1;
    endfunction

    // Tick index one full bit period after the previous mid-bit sample.
    function automatic int mid_bit(input int os);
        return os - 1;
    endfunction

    localparam int MID_START = UART_OVERSAMPLE / 2 - 1;
    localparam int MID_BIT   = UART_OVERSAMPLE - 1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value should match the input's idle level.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled, start/stop validation,
// valid/ready byte output with framing and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iRX_BAUD16_tick,
    input  logic                 iRX_SERIAL,
    input  logic                 iABORT,
    input  logic                 iRX_READY,
    output logic [DATA_BITS-1:0] oRX_DATA,
    output logic                 oRX_VALID,
    output logic                 oFRAME_ERR,
    output logic                 oOVERRUN,
    output logic                 oBUSY
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_HALF = TW'(mid_start(OVERSAMPLE));
    localparam logic [TW-1:0] T_FULL = TW'(mid_bit(OVERSAMPLE));
    localparam logic [2:0]    B_LAST = 3'(DATA_BITS - 1);

    rx_state_t            state;
    logic [TW-1:0]        tick_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 rx_s;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (iRX_SERIAL),
        .q     (rx_s)
    );

    assign oBUSY = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            oRX_DATA   <= '0;
            oRX_VALID  <= 1'b0;
            oFRAME_ERR <= 1'b0;
            oOVERRUN   <= 1'b0;
        end else begin
            oFRAME_ERR <= 1'b0;
            oOVERRUN   <= 1'b0;
            if (oRX_VALID && iRX_READY) begin
                oRX_VALID <= 1'b0;
            end
            if (iABORT) begin
                state    <= IDLE;
                tick_cnt <= '0;
                bit_cnt  <= '0;
                shift    <= '0;
            end else if (iRX_BAUD16_tick) begin
                unique case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                        end
                    end
                    START: begin
                        if (tick_cnt == T_HALF) begin
                            // A high line here means the falling edge was noise.
                            state    <= rx_s ? IDLE : DATA;
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == T_FULL) begin
                            shift   <= {rx_s, shift[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == B_LAST) begin
                                state    <= STOP;
                                tick_cnt <= '0;
                            end
                        end
                    end
                    STOP: begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == T_FULL) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                state <= IDLE;
                                if (!oRX_VALID || iRX_READY) begin
                                    oRX_DATA  <= shift;
                                    oRX_VALID <= 1'b1;
                                end else begin
                                    oOVERRUN <= 1'b1;
                                end
                            end else begin
                                oFRAME_ERR <= 1'b1;
                                state      <= WAIT_HIGH;
                            end
                        end
                    end
                    WAIT_HIGH: begin
                        // Hold off until the line idles so a break cannot restart.
                        if (rx_s) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: hand-computed frames, glitch,
// framing error, overrun, reset and abort scenarios.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       serial;
    logic       abort;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int fe_n = 0;
    int ov_n = 0;
    int fe_base;
    int ov_base;

    logic       v_before;
    logic       v_after;
    logic [7:0] d_after;
    logic       busy_after;

    uart_rx dut (
        .clk             (clk),
        .reset           (reset),
        .iRX_BAUD16_tick (tick),
        .iRX_SERIAL      (serial),
        .iABORT          (abort),
        .iRX_READY       (ready),
        .oRX_DATA        (data),
        .oRX_VALID       (valid),
        .oFRAME_ERR      (frame_err),
        .oOVERRUN        (overrun),
        .oBUSY           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err) fe_n <= fe_n + 1;
        if (overrun) ov_n <= ov_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One oversample tick every 4 clocks; returns at the negedge after it.
    task automatic tk(input logic rdy = 1'b0, input logic ab = 1'b0);
        repeat (3) @(negedge clk);
        tick  = 1'b1;
        ready = rdy;
        abort = ab;
        @(negedge clk);
        tick  = 1'b0;
        ready = 1'b0;
        abort = 1'b0;
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        serial = 1'b0;
        repeat (16) tk();
        for (int i = 0; i < nbits; i++) begin
            serial = b[i];
            repeat (16) tk();
        end
    endtask

    // Stop bit is sampled on its 9th tick; rdy is driven only in that cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic rdy);
        send_partial(b, 8);
        serial = stop;
        repeat (8) tk();
        v_before = valid;
        tk(rdy);
        v_after    = valid;
        d_after    = data;
        busy_after = busy;
        repeat (7) tk();
    endtask

    task automatic pop();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        tick   = 1'b0;
        serial = 1'b1;
        abort  = 1'b0;
        ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        reset = 1'b0;
        repeat (4) tk();

        // 0x55, consumer not ready
        fe_base = fe_n;
        ov_base = ov_n;
        send_frame(8'h55, 1'b1, 1'b0);
        chk("t1_valid_pre", v_before, 0);
        chk("t1_valid_lat", v_after, 1);
        chk("t1_data", d_after, 8'h55);
        chk("t1_busy", busy_after, 0);
        chk("t1_hold", data, 8'h55);
        pop();
        chk("t1_pop", valid, 0);
        chk("t1_noerr", fe_n - fe_base, 0);
        chk("t1_noovr", ov_n - ov_base, 0);

        // start glitch of 4 ticks
        serial = 1'b0;
        repeat (4) tk();
        serial = 1'b1;
        chk("t2_busy_start", busy, 1);
        repeat (4) tk();
        chk("t2_busy_before", busy, 1);
        tk();
        chk("t2_busy_drop", busy, 0);
        chk("t2_valid", valid, 0);
        chk("t2_noerr", fe_n - fe_base, 0);
        repeat (8) tk();

        // framing error followed by a break, then a good frame
        send_frame(8'hA3, 1'b0, 1'b0);
        chk("t3_valid", v_after, 0);
        chk("t3_busy_wh", busy_after, 1);
        repeat (48) tk();
        chk("t3_busy_break", busy, 1);
        chk("t3_ferr_once", fe_n - fe_base, 1);
        serial = 1'b1;
        tk();
        chk("t3_busy_idle", busy, 0);
        repeat (4) tk();
        send_frame(8'h3C, 1'b1, 1'b0);
        chk("t3_valid2", v_after, 1);
        chk("t3_data2", d_after, 8'h3C);
        chk("t3_ferr_total", fe_n - fe_base, 1);
        pop();

        // overrun: second byte dropped
        ov_base = ov_n;
        send_frame(8'h11, 1'b1, 1'b0);
        chk("t4_data1", d_after, 8'h11);
        send_frame(8'h22, 1'b1, 1'b0);
        chk("t4_valid_pre", v_before, 1);
        chk("t4_valid", v_after, 1);
        chk("t4_data_kept", d_after, 8'h11);
        chk("t4_ovr", ov_n - ov_base, 1);
        pop();
        chk("t4_pop", valid, 0);

        // ready exactly in the completion cycle: no overrun
        ov_base = ov_n;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        chk("t5_valid", v_after, 1);
        chk("t5_data", d_after, 8'h22);
        chk("t5_still", valid, 1);
        chk("t5_noovr", ov_n - ov_base, 0);

        // reset mid data bit 4 of 0xF0 while a byte is held
        send_partial(8'hF0, 4);
        serial = 1'b1;
        repeat (8) tk();
        chk("t6_busy_pre", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", valid, 0);
        chk("t6_rst_data", data, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ferr", frame_err, 0);
        reset = 1'b0;
        repeat (20) tk();
        chk("t6_idle", busy, 0);

        // abort on a tick during bit 2 of 0x5A
        fe_base = fe_n;
        send_partial(8'h5A, 2);
        serial = 1'b0;
        repeat (4) tk();
        chk("t6_busy_ab_pre", busy, 1);
        tk(1'b0, 1'b1);
        serial = 1'b1;
        chk("t6_abort_busy", busy, 0);
        repeat (150) tk();
        chk("t6_abort_valid", valid, 0);
        chk("t6_abort_noerr", fe_n - fe_base, 0);
        send_frame(8'h81, 1'b1, 1'b0);
        chk("t6_valid", v_after, 1);
        chk("t6_data", d_after, 8'h81);
        pop();
        chk("t6_pop", valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
